// File: rtl/fifo_rd_drain_ctrl_if.sv
// Handshake bundle between the FIFO read port, the drain controller and the TX serializer.
// The master modport is the drain controller's view; slave is the FIFO/serializer side.
interface fifo_rd_drain_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             i_rempty;
  logic [WIDTH-1:0] i_RD_Data;
  logic             o_rinc;
  logic             i_tx_busy;
  logic [WIDTH-1:0] o_tx_data;
  logic             o_tx_valid;
  logic             o_busy;
  logic [CNT_W-1:0] o_word_cnt;
  logic             o_ack_err;

  modport master (
    input  i_rempty, i_RD_Data, i_tx_busy,
    output o_rinc, o_tx_data, o_tx_valid, o_busy, o_word_cnt, o_ack_err
  );

  modport slave (
    output i_rempty, i_RD_Data, i_tx_busy,
    input  o_rinc, o_tx_data, o_tx_valid, o_busy, o_word_cnt, o_ack_err
  );
endinterface

// File: rtl/fifo_rd_drain_ctrl.sv
// Read-side FIFO drain: pops one word when the serializer is idle, strobes it out,
// follows the busy handshake (with timeout resend) and pauses GAP cycles between words.
module fifo_rd_drain_ctrl #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  parameter int ACK_TO = 8,
  parameter int GAP    = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  fifo_rd_drain_ctrl_if.master bus
);
  // One timer serves both the ack timeout and the inter-word gap.
  localparam int TMR_MAX = (ACK_TO > GAP) ? ACK_TO : GAP;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'((ACK_TO > 0) ? ACK_TO - 1 : 0);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    GAP_ST    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               ack_err_q, ack_err_d;
  logic               rinc_q, tx_valid_q, busy_q;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    tx_data_d  = tx_data_q;
    word_cnt_d = word_cnt_q;
    ack_err_d  = ack_err_q;
    case (state_q)
      IDLE: begin
        // Show-ahead data is captured on the same edge that raises the pop strobe.
        if (!bus.i_rempty && !bus.i_tx_busy) begin
          state_d   = POP;
          tx_data_d = bus.i_RD_Data;
        end
      end
      POP: state_d = SEND;
      SEND: begin
        state_d = WAIT_ACK;
        tmr_d   = '0;
      end
      WAIT_ACK: begin
        if (bus.i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_q == ACK_LAST) begin
          ack_err_d = 1'b1;
          state_d   = SEND;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          word_cnt_d = word_cnt_q + 1'b1;
          tmr_d      = '0;
          state_d    = (GAP == 0) ? IDLE : GAP_ST;
        end
      end
      GAP_ST: begin
        if (tmr_q == GAP_LAST) state_d = IDLE;
        else                   tmr_d   = tmr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with POP/SEND exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      tx_data_q  <= '0;
      word_cnt_q <= '0;
      ack_err_q  <= 1'b0;
      rinc_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tx_data_q  <= tx_data_d;
      word_cnt_q <= word_cnt_d;
      ack_err_q  <= ack_err_d;
      rinc_q     <= (state_d == POP);
      tx_valid_q <= (state_d == SEND);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.o_rinc     = rinc_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_word_cnt = word_cnt_q;
  assign bus.o_ack_err  = ack_err_q;
endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// Bench for fifo_rd_drain_ctrl: queue FIFO model and TX busy model drive the DUT,
// a negedge monitor pops expected words from a scoreboard queue on every fresh valid.
module tb_fifo_rd_drain_ctrl;
  localparam int WIDTH    = 8;
  localparam int CNT_W    = 16;
  localparam int ACK_TO   = 8;
  localparam int GAP      = 2;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_drain_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_rd_drain_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACK_TO(ACK_TO), .GAP(GAP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_word = '0;
  int  ignore_n   = 0;
  logic force_busy = 1'b0;
  int  rinc_cnt = 0;
  int  last_rinc_cyc = 0;
  int  valid_last_cyc = 0;
  int  valid_prev_cyc = 0;
  logic prev_rinc = 1'b0;

  logic [WIDTH-1:0] burst [16] = '{8'h3F, 8'h81, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78,
                                   8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h7E, 8'hC3, 8'h2D};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO and serializer models; updated #1 after each edge from pre-edge strobes.
  initial begin : env
    int busy_cnt;
    logic rinc_s, valid_s;
    busy_cnt = 0;
    bus.i_rempty  = 1'b1;
    bus.i_RD_Data = '0;
    bus.i_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      rinc_s  = bus.o_rinc;
      valid_s = bus.o_tx_valid;
      #1;
      if (rinc_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (valid_s) begin
        if (ignore_n > 0) ignore_n--;
        else              busy_cnt = BUSY_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.i_tx_busy = force_busy || (busy_cnt > 0);
      bus.i_rempty  = (fifo_q.size() == 0);
      bus.i_RD_Data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (prev_rinc) chk("valid_after_rinc", 32'(bus.o_tx_valid), 32'd1);
      if (bus.o_rinc) begin
        rinc_cnt++;
        last_rinc_cyc = cyc;
        chk("rinc_back2back", 32'(prev_rinc), 32'd0);
        chk("pop_nonempty", 32'(bus.i_rempty), 32'd0);
      end
      if (bus.o_tx_valid) begin
        valid_prev_cyc = valid_last_cyc;
        valid_last_cyc = cyc;
        if (prev_rinc) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=0x%0h required=none", bus.o_tx_data);
          end else begin
            last_word = exp_q.pop_front();
            chk("tx_data", 32'(bus.o_tx_data), 32'(last_word));
          end
        end else begin
          chk("resend_data", 32'(bus.o_tx_data), 32'(last_word));
        end
        $display("word tx_data=0x%02h resend=%0d cycle=%0d", bus.o_tx_data, !prev_rinc, cyc);
      end
      prev_rinc = bus.o_rinc;
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_words(input int target, input string name);
    int n;
    n = 0;
    while (bus.o_word_cnt != CNT_W'(target) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.o_word_cnt), 32'(target));
    n = 0;
    while (bus.o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int rel_cyc;
    int n;

    // 1: reset with FIFO empty
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rinc",     32'(bus.o_rinc),     32'd0);
    chk("rst_valid",    32'(bus.o_tx_valid), 32'd0);
    chk("rst_tx_data",  32'(bus.o_tx_data),  32'd0);
    chk("rst_busy",     32'(bus.o_busy),     32'd0);
    chk("rst_word_cnt", 32'(bus.o_word_cnt), 32'd0);
    chk("rst_ack_err",  32'(bus.o_ack_err),  32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("empty_no_pop", 32'(rinc_cnt), 32'd0);

    // 2: single word
    base = rinc_cnt;
    push_word(8'hA5);
    wait_words(1, "single_cnt");
    chk("single_pops",    32'(rinc_cnt - base), 32'd1);
    chk("single_data",    32'(bus.o_tx_data),   32'hA5);
    chk("single_ack_err", 32'(bus.o_ack_err),   32'd0);

    // 3: burst of 16
    base = rinc_cnt;
    for (int i = 0; i < 16; i++) push_word(burst[i]);
    wait_words(17, "burst_cnt");
    chk("burst_pops", 32'(rinc_cnt - base), 32'd16);

    // 4: first valid ignored, resend acked
    base = rinc_cnt;
    ignore_n = 1;
    push_word(8'h3C);
    wait_words(18, "timeout_cnt");
    chk("timeout_pops",    32'(rinc_cnt - base),               32'd1);
    chk("timeout_ack_err", 32'(bus.o_ack_err),                 32'd1);
    chk("resend_gap",      32'(valid_last_cyc - valid_prev_cyc), 32'(ACK_TO + 1));

    // 5: busy blocks the pop while data waits
    base = rinc_cnt;
    force_busy = 1'b1;
    push_word(8'h5A);
    repeat (30) @(negedge clk);
    chk("blocked_pops", 32'(rinc_cnt - base), 32'd0);
    chk("blocked_busy", 32'(bus.o_busy),      32'd0);
    force_busy = 1'b0;
    rel_cyc = cyc + 1;
    wait_words(19, "release_cnt");
    chk("release_latency", 32'(last_rinc_cyc - rel_cyc), 32'd1);

    // 6: reset while waiting for the serializer to finish
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    n = 0;
    while (!bus.o_tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_valid_seen", 32'(bus.o_tx_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid_in_wait_done", 32'(bus.i_tx_busy && bus.o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",     32'(bus.o_busy),     32'd0);
    chk("mid_rst_word_cnt", 32'(bus.o_word_cnt), 32'd0);
    chk("mid_rst_ack_err",  32'(bus.o_ack_err),  32'd0);
    chk("mid_rst_tx_data",  32'(bus.o_tx_data),  32'd0);
    base = rinc_cnt;
    wait_words(2, "drain_cnt");
    chk("drain_pops",     32'(rinc_cnt - base), 32'd2);
    chk("drain_fifo_len", 32'(fifo_q.size()),   32'd0);
    chk("drain_exp_len",  32'(exp_q.size()),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
